// File: rtl/nfc_rng_gen.sv
// nfc_rng_gen: pattern generator/checker producing DW-bit words from 32-bit state.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst      - synchronous active-high reset
//   en       - generator enable; rising edge (en=1 while en_dly=0) loads seed
//   seed     - 32-bit initial state
//   mode     - 00 LFSR, 01 hold, 10 increment, 11 decrement
//   rd       - consumer advance strobe
//   chk_vld  - incoming check data valid (also advances when the checker is built)
//   chk_dat  - incoming data compared against dat_out
//   dat_out  - current generated word, combinational from registers
//   err_cnt  - saturating mismatch count
//   err_flag - sticky mismatch indicator
//
// Optional feature: define NFC_RNG_CHK_EN to build the mismatch checker. Without it
// err_cnt/err_flag are tied low and chk_vld/chk_dat are ignored.

module nfc_rng_gen #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      seed,
  input  logic [1:0]       mode,
  input  logic             rd,
  input  logic             chk_vld,
  input  logic [DW-1:0]    chk_dat,
  output logic [DW-1:0]    dat_out,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag
);

  localparam int unsigned L  = 32 / DW;
  // Keep at least one bit of lane index so single-lane builds stay legal.
  localparam int unsigned IW = (L > 1) ? $clog2(L) : 1;
  localparam logic [IW-1:0] IdxLast = IW'(L - 1);

  typedef enum logic [1:0] {
    ModeLfsr = 2'b00,
    ModeHold = 2'b01,
    ModeInc  = 2'b10,
    ModeDec  = 2'b11
  } mode_e;

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  logic [31:0]   st_q, st_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          en_dly_q;
  logic          load;
  logic          adv;
  logic          lfsr_fb;

  assign load    = en & ~en_dly_q;
  assign lfsr_fb = st_q[31] ^ st_q[6] ^ st_q[4] ^ st_q[2] ^ st_q[1] ^ st_q[0];
  assign dat_out = st_q[int'(idx_q) * DW +: DW];

  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    if (load) begin
      // An all-zero LFSR state would lock up, so substitute 1.
      st_d  = ((mode_sel == ModeLfsr) && (seed == 32'h0)) ? 32'h0000_0001 : seed;
      idx_d = IdxLast;
    end else if (!en) begin
      idx_d = IdxLast;
    end else begin
      case (mode_sel)
        ModeLfsr: begin
          // Walk the lanes of the current word before stepping the LFSR.
          if (adv) begin
            if (idx_q == IdxLast) begin
              st_d  = {st_q[30:0], lfsr_fb};
              idx_d = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        ModeHold: begin
          idx_d = IdxLast;
        end
        ModeInc: begin
          idx_d = IdxLast;
          if (adv) st_d[31 -: DW] = st_q[31 -: DW] + DW'(1);
        end
        default: begin
          idx_d = IdxLast;
          if (adv) st_d[31 -: DW] = st_q[31 -: DW] - DW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= '0;
      idx_q    <= IdxLast;
      en_dly_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      idx_q    <= idx_d;
      en_dly_q <= en;
    end
  end

`ifdef NFC_RNG_CHK_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_flag_q, err_flag_d;

  assign adv = en & en_dly_q & (rd | chk_vld);

  // Compared against the pre-advance word, i.e. the one currently on dat_out.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (load) begin
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end else if (adv && chk_vld && (chk_dat != dat_out)) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;
`else
  logic unused_chk;

  assign adv        = en & en_dly_q & rd;
  assign err_cnt    = '0;
  assign err_flag   = 1'b0;
  assign unused_chk = ^{chk_vld, chk_dat};
`endif

endmodule

// File: tb/tb_nfc_rng_gen.sv
// Scoreboard bench for nfc_rng_gen: one DW=8/CNT_W=2 instance and one DW=32 instance
// share stimulus; expectations are queued by the stimulus and checked on the falling edge.

module tb_nfc_rng_gen;

`ifdef NFC_RNG_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] seed;
  logic [1:0]  mode;
  logic        rd;
  logic        chk_vld;
  logic [7:0]  chk_dat8;
  logic [31:0] chk_dat32;
  logic [7:0]  dat8;
  logic [1:0]  cnt8;
  logic        flg8;
  logic [31:0] dat32;
  logic [15:0] cnt32;
  logic        flg32;

  nfc_rng_gen #(.DW(8), .CNT_W(2)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .seed     (seed),
    .mode     (mode),
    .rd       (rd),
    .chk_vld  (chk_vld),
    .chk_dat  (chk_dat8),
    .dat_out  (dat8),
    .err_cnt  (cnt8),
    .err_flag (flg8)
  );

  nfc_rng_gen #(.DW(32), .CNT_W(16)) u_dut32 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .seed     (seed),
    .mode     (mode),
    .rd       (rd),
    .chk_vld  (chk_vld),
    .chk_dat  (chk_dat32),
    .dat_out  (dat32),
    .err_cnt  (cnt32),
    .err_flag (flg32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          wide;
    logic [31:0] dat;
    logic [1:0]  cnt;
    logic        flg;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Monitor: outputs are register-driven, so the falling edge sees settled values.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (mon_e.wide) begin
        if (dat32 !== mon_e.dat)
          $display("FAIL %s: got dat=%h, expected dat=%h", mon_e.name, dat32, mon_e.dat);
        else
          n_pass++;
      end else begin
        if ({dat8, cnt8, flg8} !== {mon_e.dat[7:0], mon_e.cnt, mon_e.flg})
          $display("FAIL %s: got dat=%h cnt=%0d flg=%b, expected dat=%h cnt=%0d flg=%b",
                   mon_e.name, dat8, cnt8, flg8, mon_e.dat[7:0], mon_e.cnt, mon_e.flg);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp8(input string nm, input logic [7:0] d, input int c, input logic f);
    exp_t e;
    e.name = nm;
    e.wide = 1'b0;
    e.dat  = {24'h0, d};
    e.cnt  = c[1:0];
    e.flg  = f;
    sb_q.push_back(e);
  endtask

  task automatic exp32(input string nm, input logic [31:0] d);
    exp_t e;
    e.name = nm;
    e.wide = 1'b1;
    e.dat  = d;
    e.cnt  = 2'd0;
    e.flg  = 1'b0;
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

  logic [7:0] lane_exp [5] = '{8'hF0, 8'hAC, 8'h68, 8'h24, 8'hE0};
  logic [7:0] chk_exp  [6] = '{8'hF0, 8'hAC, 8'h68, 8'h24, 8'hE0, 8'h59};
  int         cnt_exp  [6] = '{0, 1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1; en = 1'b0; seed = '0; mode = 2'b00; rd = 1'b0;
    chk_vld = 1'b0; chk_dat8 = '0; chk_dat32 = '0;
    tick();
    tick();
    exp8("reset8", 8'h00, 0, 1'b0);
    exp32("reset32", 32'h0);

    // LFSR lane walk from seed 12345678.
    rst = 1'b0; seed = 32'h1234_5678; mode = 2'b00; en = 1'b1;
    tick();
    exp8("load8", 8'h12, 0, 1'b0);
    exp32("load32", 32'h1234_5678);
    rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp8($sformatf("lfsr8_%0d", i), lane_exp[i], 0, 1'b0);
      if (i == 0) exp32("lfsr32_0", 32'h2468_ACF0);
      if (i == 1) exp32("lfsr32_1", 32'h48D1_59E0);
    end
    rd = 1'b0;
    tick();
    exp8("no_rd_hold", 8'hE0, 0, 1'b0);

    // Disable: idx returns to the top lane, st held, rd ignored.
    en = 1'b0;
    tick();
    exp8("en_off_top_lane", 8'h48, 0, 1'b0);
    rd = 1'b1;
    tick();
    exp8("rd_while_off", 8'h48, 0, 1'b0);
    rd = 1'b0;

    // Zero seed in LFSR mode is replaced with 1.
    seed = 32'h0; en = 1'b1;
    tick();
    exp8("zero_seed8", 8'h00, 0, 1'b0);
    exp32("zero_seed32", 32'h0000_0001);

    // Increment with wrap.
    en = 1'b0;
    tick();
    mode = 2'b10; seed = 32'hFF00_0000; en = 1'b1;
    tick();
    exp8("inc_load8", 8'hFF, 0, 1'b0);
    exp32("inc_load32", 32'hFF00_0000);
    rd = 1'b1;
    tick();
    exp8("inc_wrap8", 8'h00, 0, 1'b0);
    exp32("inc32", 32'hFF00_0001);
    rd = 1'b0;

    // Decrement with wrap; zero seed kept outside LFSR mode.
    en = 1'b0;
    tick();
    mode = 2'b11; seed = 32'h0; en = 1'b1;
    tick();
    exp8("dec_load8", 8'h00, 0, 1'b0);
    exp32("dec_load32", 32'h0);
    rd = 1'b1;
    tick();
    exp8("dec_wrap8", 8'hFF, 0, 1'b0);
    exp32("dec_wrap32", 32'hFFFF_FFFF);
    rd = 1'b0;

    // Checker: one matching word, then five mismatches against 00.
    en = 1'b0;
    tick();
    mode = 2'b00; seed = 32'h1234_5678; en = 1'b1;
    tick();
    exp8("chk_load", 8'h12, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk_vld  = 1'b1;
      chk_dat8 = (i == 0) ? 8'h12 : 8'h00;
      tick();
      exp8($sformatf("chk_%0d", i), ChkEn ? chk_exp[i] : 8'h12,
           ChkEn ? cnt_exp[i] : 0, ChkEn ? (i > 0) : 1'b0);
    end
    chk_vld = 1'b0; chk_dat8 = 8'h00;
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    exp8("reload_clear", 8'h12, 0, 1'b0);

    // Reset mid-lane, rd ignored until a new load, load beats rd, hold mode.
    rd = 1'b1;
    tick();
    tick();
    exp8("mid_lane", 8'hAC, 0, 1'b0);
    rst = 1'b1; en = 1'b0;
    tick();
    exp8("rst_mid8", 8'h00, 0, 1'b0);
    exp32("rst_mid32", 32'h0);
    rst = 1'b0;
    tick();
    tick();
    exp8("rd_after_rst", 8'h00, 0, 1'b0);
    en = 1'b1;
    tick();
    exp8("load_wins", 8'h12, 0, 1'b0);
    tick();
    exp8("adv_after_load", 8'hF0, 0, 1'b0);
    tick();
    exp8("lane1", 8'hAC, 0, 1'b0);
    mode = 2'b01;
    tick();
    exp8("hold_top_lane", 8'h24, 0, 1'b0);
    tick();
    exp8("hold_stable", 8'h24, 0, 1'b0);
    rd = 1'b0;

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
